// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage rvseed core: load-use stalls, redirect flushes,
// memory freezes and registered EX operand forwarding selects. Optional counters: HAZARD_PERF_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 7
`endif

module hazard_ctrl #(
    parameter int RADDR_W = `REG_ADDR_WIDTH,
    parameter int FWD_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_wen,
    input  logic               id_load,
    input  logic               ex_redirect,
    input  logic               mem_busy,
    output logic               stall_if,
    output logic               stall_id,
    output logic               stall_ex,
    output logic               stall_mem,
    output logic               flush_if,
    output logic               flush_id,
    output logic [FWD_W-1:0]   fwd_rs1_sel,
    output logic [FWD_W-1:0]   fwd_rs2_sel,
`ifdef HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
    output logic [31:0]        perf_freeze_cnt,
`endif
    output logic [1:0]         ctrl_state
);

    typedef enum logic [1:0] {
        ACT_RUN      = 2'd0,
        ACT_LU_STALL = 2'd1,
        ACT_FLUSH    = 2'd2,
        ACT_FREEZE   = 2'd3
    } act_e;

    act_e act;
    act_e state_q, state_d;

    // The regfile is write-through, so only the EX and MEM shadow entries can feed a forward.
    logic               ex_valid_q, ex_valid_d;
    logic [RADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic               ex_wen_q, ex_wen_d;
    logic               ex_load_q, ex_load_d;
    logic               mem_valid_q, mem_valid_d;
    logic [RADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic               mem_wen_q, mem_wen_d;
    logic [FWD_W-1:0]   fwd_rs1_q, fwd_rs1_d;
    logic [FWD_W-1:0]   fwd_rs2_q, fwd_rs2_d;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, lu;

    function automatic logic src_hit(input logic v, input logic w, input logic [RADDR_W-1:0] rd,
                                     input logic [RADDR_W-1:0] src, input logic use_src);
        return v & w & (rd != '0) & (rd == src) & use_src;
    endfunction

    function automatic logic [FWD_W-1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_W'(1);
        else if (mem_hit) return FWD_W'(2);
        else              return '0;
    endfunction

    always_comb begin
        ex_hit1  = src_hit(ex_valid_q, ex_wen_q, ex_rd_q, id_rs1, id_use_rs1);
        ex_hit2  = src_hit(ex_valid_q, ex_wen_q, ex_rd_q, id_rs2, id_use_rs2);
        mem_hit1 = src_hit(mem_valid_q, mem_wen_q, mem_rd_q, id_rs1, id_use_rs1);
        mem_hit2 = src_hit(mem_valid_q, mem_wen_q, mem_rd_q, id_rs2, id_use_rs2);
        lu       = id_valid & ex_load_q & (ex_hit1 | ex_hit2);
    end

    always_comb begin
        act = ACT_RUN;
        if (mem_busy)         act = ACT_FREEZE;
        else if (ex_redirect) act = ACT_FLUSH;
        else if (lu)          act = ACT_LU_STALL;
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        if (!rst) begin
            case (act)
                ACT_FREEZE: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                end
                ACT_FLUSH: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end
                ACT_LU_STALL: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_id = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = act;
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_wen_d    = ex_wen_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_wen_d   = mem_wen_q;
        fwd_rs1_d   = fwd_rs1_q;
        fwd_rs2_d   = fwd_rs2_q;
        if (act != ACT_FREEZE) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_wen_d   = ex_wen_q;
            ex_valid_d  = 1'b0;
            ex_rd_d     = '0;
            ex_wen_d    = 1'b0;
            ex_load_d   = 1'b0;
            if (act == ACT_RUN && id_valid) begin
                ex_valid_d = 1'b1;
                ex_rd_d    = id_rd;
                ex_wen_d   = id_wen;
                ex_load_d  = id_load;
                // A load in EX never reaches here with a match; that case is LU_STALL.
                fwd_rs1_d  = fwd_sel(ex_hit1 & ~ex_load_q, mem_hit1);
                fwd_rs2_d  = fwd_sel(ex_hit2 & ~ex_load_q, mem_hit2);
            end
            if (act == ACT_FLUSH) begin
                fwd_rs1_d = '0;
                fwd_rs2_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACT_RUN;
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wen_q    <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wen_q   <= 1'b0;
            fwd_rs1_q   <= '0;
            fwd_rs2_q   <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wen_q    <= ex_wen_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wen_q   <= mem_wen_d;
            fwd_rs1_q   <= fwd_rs1_d;
            fwd_rs2_q   <= fwd_rs2_d;
        end
    end

    assign ctrl_state  = state_q;
    assign fwd_rs1_sel = fwd_rs1_q;
    assign fwd_rs2_sel = fwd_rs2_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (act == ACT_LU_STALL && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        if (act == ACT_FLUSH && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
        if (act == ACT_FREEZE && freeze_cnt_q != 32'hFFFF_FFFF) freeze_cnt_d = freeze_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
    assign perf_freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan scenarios followed by randomized
// traffic, all checked against an instruction-level pipeline model.
`timescale 1ns/1ps

module tb_hazard_ctrl;
    localparam int RW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_wen, id_load, ex_redirect, mem_busy;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

    hazard_ctrl #(.RADDR_W(RW), .FWD_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_if(flush_if), .flush_id(flush_id),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_freeze_cnt(perf_freeze_cnt),
`endif
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    // Reference model: one record per in-flight instruction, pipe[0] in EX, pipe[1] in MEM.
    typedef struct {
        bit          valid;
        logic [RW-1:0] rd;
        bit          wen;
        bit          load;
    } instr_t;

    instr_t      pipe[$];
    int          m_fwd1, m_fwd2, m_state;
    int unsigned m_cnt_stall, m_cnt_flush, m_cnt_freeze;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    function automatic int x(input int n);
        return n * 4;
    endfunction

    function automatic bit writes(input instr_t i, input logic [RW-1:0] src, input bit use_src);
        return use_src && i.valid && i.wen && (i.rd != 0) && (i.rd == src);
    endfunction

    // Forward distance: 1 if the youngest in-flight writer is in EX, 2 if in MEM, else 0.
    function automatic int fwd_dist(input logic [RW-1:0] src, input bit use_src);
        for (int k = 0; k < 2; k++)
            if (writes(pipe[k], src, use_src)) return k + 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        instr_t b;
        b = '{valid: 1'b0, rd: '0, wen: 1'b0, load: 1'b0};
        pipe = '{b, b};
        m_fwd1 = 0;
        m_fwd2 = 0;
        m_state = 0;
        m_cnt_stall = 0;
        m_cnt_flush = 0;
        m_cnt_freeze = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones after posedge.
    task automatic cycle(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                         input int rd, input bit w, input bit ld, input bit redir, input bit busy);
        int     act;
        bit     lu;
        bit     r;
        instr_t nw;
        @(negedge clk);
        id_valid = v; id_rs1 = RW'(r1); id_rs2 = RW'(r2);
        id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = RW'(rd); id_wen = w; id_load = ld;
        ex_redirect = redir; mem_busy = busy;
        #1;
        r  = rst;
        lu = v && pipe[0].load && (writes(pipe[0], RW'(r1), u1) || writes(pipe[0], RW'(r2), u2));
        if (busy)       act = 3;
        else if (redir) act = 2;
        else if (lu)    act = 1;
        else            act = 0;
        check("stall_if",  stall_if,  !r && (act == 1 || act == 3));
        check("stall_id",  stall_id,  !r && (act == 1 || act == 3));
        check("stall_ex",  stall_ex,  !r && act == 3);
        check("stall_mem", stall_mem, !r && act == 3);
        check("flush_if",  flush_if,  !r && act == 2);
        check("flush_id",  flush_id,  !r && (act == 1 || act == 2));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_state = act;
            if (act == 1 && m_cnt_stall  != 32'hFFFF_FFFF) m_cnt_stall++;
            if (act == 2 && m_cnt_flush  != 32'hFFFF_FFFF) m_cnt_flush++;
            if (act == 3 && m_cnt_freeze != 32'hFFFF_FFFF) m_cnt_freeze++;
            if (act != 3) begin
                nw = '{valid: 1'b0, rd: '0, wen: 1'b0, load: 1'b0};
                if (act == 0 && v) begin
                    nw = '{valid: 1'b1, rd: RW'(rd), wen: w, load: ld};
                    m_fwd1 = fwd_dist(RW'(r1), u1);
                    m_fwd2 = fwd_dist(RW'(r2), u2);
                end
                if (act == 2) begin
                    m_fwd1 = 0;
                    m_fwd2 = 0;
                end
                void'(pipe.pop_back());
                pipe.push_front(nw);
            end
        end
        #1;
        check("ctrl_state",  ctrl_state,  m_state);
        check("fwd_rs1_sel", fwd_rs1_sel, m_fwd1);
        check("fwd_rs2_sel", fwd_rs2_sel, m_fwd2);
`ifdef HAZARD_PERF_EN
        check("perf_stall",  perf_stall_cnt,  m_cnt_stall);
        check("perf_flush",  perf_flush_cnt,  m_cnt_flush);
        check("perf_freeze", perf_freeze_cnt, m_cnt_freeze);
`endif
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = '0; id_wen = 0; id_load = 0; ex_redirect = 0; mem_busy = 0;
        model_reset();

        // Reset, with hazard-looking inputs present: everything must stay quiet.
        cycle(1, x(1), 0, 1, 0, x(2), 1, 1, 1, 0);
        cycle(1, x(1), 0, 1, 0, x(2), 1, 1, 0, 1);
        check("rst_state", ctrl_state, 0);
        rst = 1'b0;

        // Load-use: lw x1, then add reading x1 -> one bubble, then forward from MEM.
        cycle(1, 0, 0, 0, 0, x(1), 1, 1, 0, 0);
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 0, 0);
        check("lu_state", ctrl_state, 1);
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 0, 0);
        check("lu_fwd1", fwd_rs1_sel, 2);

        // Back-to-back ALU producer/consumer, one-gap and two-gap distance.
        cycle(1, 0, 0, 0, 0, x(2), 1, 0, 0, 0);
        cycle(1, 0, x(2), 0, 1, x(6), 1, 0, 0, 0);
        check("alu_fwd_ex", fwd_rs2_sel, 1);
        cycle(1, 0, 0, 0, 0, x(2), 1, 0, 0, 0);
        cycle(1, x(7), 0, 1, 0, x(5), 1, 0, 0, 0);
        cycle(1, 0, x(2), 0, 1, x(6), 1, 0, 0, 0);
        check("alu_fwd_mem", fwd_rs2_sel, 2);
        cycle(1, 0, x(2), 0, 1, x(6), 1, 0, 0, 0);
        check("alu_fwd_none", fwd_rs2_sel, 0);

        // x0 as destination never matches, including a load to x0.
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, x(4), 1, 0, 0, 0);
        check("x0_fwd1", fwd_rs1_sel, 0);
        check("x0_fwd2", fwd_rs2_sel, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(1, 0, 0, 1, 1, x(4), 1, 0, 0, 0);
        check("x0_load_state", ctrl_state, 0);

        // Redirect wins over a simultaneous load-use.
        cycle(1, 0, 0, 0, 0, x(1), 1, 1, 0, 0);
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 1, 0);
        check("redir_state", ctrl_state, 2);
        nop();

        // Freeze for 3 cycles with redirect pending: selects hold, then FLUSH.
        cycle(1, 0, 0, 0, 0, x(2), 1, 0, 0, 0);
        cycle(1, 0, x(2), 0, 1, x(6), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, x(6), 0, 1, 0, x(7), 1, 0, 1, 1);
            check("frz_state", ctrl_state, 3);
            check("frz_fwd2_hold", fwd_rs2_sel, 1);
        end
        cycle(1, x(6), 0, 1, 0, x(7), 1, 0, 1, 0);
        check("frz_then_flush", ctrl_state, 2);
        check("flush_fwd2", fwd_rs2_sel, 0);
        nop();

        // Reset in the middle of a load-use stall: the old load is forgotten.
        cycle(1, 0, 0, 0, 0, x(1), 1, 1, 0, 0);
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 0, 0);
        rst = 1'b1;
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 0, 0);
        check("rst_mid_state", ctrl_state, 0);
        rst = 1'b0;
        cycle(1, x(1), 0, 1, 0, x(3), 1, 0, 0, 0);
        check("rst_mid_fwd1", fwd_rs1_sel, 0);
        check("rst_mid_issue", ctrl_state, 0);

        // Randomized traffic over a small register set to keep hazards frequent.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            cycle($urandom_range(0, 4) != 0,
                  x($urandom_range(0, 3)), x($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  x($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage rvseed core (IF/ID/EX/MEM/WB).
- Consumes per-instruction control fields produced by the ID-stage instruction decoder and tracks in-flight destinations in internal EX/MEM/WB shadow stages.
- Issues stall, flush and forwarding selects for load-use hazards, EX-stage branch/jump redirects and multi-cycle memory freezes.

Parameters:
- RADDR_W, `REG_ADDR_WIDTH, width of the register addresses exactly as emitted by the decoder (index << 2).
- FWD_W, 2, width of each forwarding select.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  RADDR_W  decoder reg1_raddr
- id_rs2  in  RADDR_W  decoder reg2_raddr
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  RADDR_W  decoder reg_waddr
- id_wen  in  1  decoder reg_wen
- id_load  in  1  decoder mem_ren & mem2reg
- ex_redirect  in  1  EX resolved taken branch/jump
- mem_busy  in  1  data memory not ready this cycle
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID/EX inputs
- stall_ex  out  1  hold EX/MEM register
- stall_mem  out  1  hold MEM/WB register
- flush_if  out  1  kill fetched instruction
- flush_id  out  1  insert bubble into EX
- fwd_rs1_sel  out  FWD_W  EX operand-1 source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
- fwd_rs2_sel  out  FWD_W  same for operand 2
- ctrl_state  out  2  action taken last cycle: 0 RUN, 1 LU_STALL, 2 FLUSH, 3 FREEZE

Behaviour:
- Clock/reset: one clock clk; rst synchronous, active-high.
- Reset values: all shadow entries invalid, fwd_* = 0, ctrl_state = RUN, counters = 0. While rst is high, all stall/flush outputs = 0.
- Shadow entry fields: {valid, rd, wen, load}. Hazard match: entry.valid & entry.wen & entry.rd != 0 & rd == source address & use flag set. rd == 0 never matches.
- lu = match of the ID sources against the EX entry with EX.load = 1.
- Action priority per cycle, highest first:
  - FREEZE: mem_busy. All four stall_* = 1, flush_* = 0, shadow stages and fwd_* hold.
  - FLUSH: ex_redirect. flush_if = flush_id = 1, stalls 0. The EX entry moves to MEM, a bubble enters EX, fwd_* <= 0.
  - LU_STALL: id_valid & lu. stall_if = stall_id = 1, flush_id = 1 (bubble), EX advances to MEM.
  - RUN: all stalls/flushes 0. EX <= ID fields if id_valid, else bubble.
- Shadow shift in every non-FREEZE cycle: WB <= MEM, MEM <= EX.
- ex_redirect held through a FREEZE is acted on in the first cycle after mem_busy drops.
- Forwarding selects are registered and loaded only on RUN issue (the instruction enters EX):
  - match vs current EX entry (non-load) -> 1;
  - else match vs current MEM entry -> 2;
  - else 0.
  - The younger EX entry wins over MEM.
  - A load in EX never forwards; it forces LU_STALL.
  - After one bubble the load sits in MEM, so the select is 2.
- The regfile is write-through, so a WB-entry match needs no forwarding.
- ctrl_state: registered code of the action chosen each cycle.
- Latency: load-use costs exactly 1 bubble; a redirect costs 2 killed slots.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_freeze_cnt (32 bits each). Each increments once per cycle of LU_STALL, FLUSH and FREEZE respectively, saturates at 0xFFFFFFFF and is cleared by rst.
- When undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- lw rd=0x04 (x1) then add rs1=0x04 -> 1 cycle stall_if = stall_id = flush_id = 1, ctrl_state = 1; add then issues with fwd_rs1_sel = 2.
- add rd=x2, then sub rs2=x2 back-to-back -> no stall, fwd_rs2_sel = 1. With one unrelated instruction between them -> fwd_rs2_sel = 2. A third consumer -> 0.
- Producer writes rd = 0 with reg_wen = 1, consumer reads x0 -> no stall, fwd = 0.
- ex_redirect = 1 at the same cycle as a load-use condition in ID -> flush_if = flush_id = 1, no stall, ctrl_state = 2.
- mem_busy high 3 cycles with ex_redirect = 1 -> 3 cycles all stall_* = 1, flush_* = 0, fwd held; the 4th cycle performs FLUSH.
- Assert rst mid load-use stall -> next cycle all outputs 0, shadow invalid; consumer of the old load issues with fwd = 0. With HAZARD_PERF_EN, counters read 0.
